// File: rtl/ram2p_pkg.sv
// Shared types and helpers for the two-port byte-enable RAM with post-reset clear.
package ram2p_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int calc_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram2p_be_clr_if.sv
// User-facing read/write port bundle; the RAM is the slave, its user the master.
interface ram2p_be_clr_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    import ram2p_pkg::*;

    localparam int NB = calc_nb(DATA_WIDTH, BYTE_WIDTH);

    logic                  busy;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  busy, rd_data, rd_valid,
        output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data
    );

    modport slave (
        output busy, rd_data, rd_valid,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data
    );

endinterface

// File: rtl/ram2p_be_core.sv
// Inferable simple-dual-port block RAM: per-lane write enable, registered read-first read.
module ram2p_be_core
    import ram2p_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          we,
    input  logic [ADDR_WIDTH-1:0]                         waddr,
    input  logic [calc_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]    wbe,
    input  logic [DATA_WIDTH-1:0]                         wdata,
    input  logic                                          re,
    input  logic [ADDR_WIDTH-1:0]                         raddr,
    output logic [DATA_WIDTH-1:0]                         rdata
);
    localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset; a reset would stop
    // block-RAM inference, and the clear sweep in the parent restores contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Non-blocking update of mem above means a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram2p_be_clr.sv
// Two-port byte-enable RAM that sweeps INIT_VALUE into every word after reset,
// with selectable write-first/read-first collision handling and optional output register.
module ram2p_be_clr
    import ram2p_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    OUT_REG    = 0,
    parameter int                    BYPASS     = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram2p_be_clr_if.slave bus
);
    localparam int                  NB       = calc_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0] CNT_STEP = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  ready;
    logic                  rd_acc;
    logic                  wr_acc;

    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [NB-1:0]         core_wbe;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  v1_q, v1_d;
    logic                  coll_q, coll_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [NB-1:0]         byp_be_q, byp_be_d;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    // The extra counter bit flags "address depth-1 written" without wrapping to 0.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + CNT_STEP;
            if (cnt_d[ADDR_WIDTH]) begin
                state_d = READY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready    = (state_q == READY);
    assign bus.busy = ~ready;
    assign rd_acc   = ready & bus.rd_en;
    assign wr_acc   = ready & bus.wr_en;

    // The sweep owns the write port while busy; user writes are dropped then.
    always_comb begin
        core_we    = 1'b1;
        core_waddr = cnt_q[ADDR_WIDTH-1:0];
        core_wbe   = '1;
        core_wdata = INIT_VALUE;
        if (ready) begin
            core_we    = wr_acc;
            core_waddr = bus.wr_addr;
            core_wbe   = bus.wr_be;
            core_wdata = bus.wr_data;
        end
    end

    ram2p_be_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wbe   (core_wbe),
        .wdata (core_wdata),
        .re    (rd_acc),
        .raddr (bus.rd_addr),
        .rdata (core_rdata)
    );

    // Collision side-info travels alongside the RAM read so the merge lines up.
    always_comb begin
        v1_d       = rd_acc;
        coll_d     = coll_q;
        byp_data_d = byp_data_q;
        byp_be_d   = byp_be_q;
        if (rd_acc) begin
            coll_d     = wr_acc & (bus.rd_addr == bus.wr_addr);
            byp_data_d = bus.wr_data;
            byp_be_d   = bus.wr_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            coll_q <= coll_d;
        end
    end

    always_ff @(posedge clk) begin
        byp_data_q <= byp_data_d;
        byp_be_q   <= byp_be_d;
    end

    // Write-first: overlay the colliding write's enabled lanes on the read-first word.
    always_comb begin
        merged = core_rdata;
        if ((BYPASS != 0) && coll_q) begin
            for (int i = 0; i < NB; i++) begin
                if (byp_be_q[i]) begin
                    merged[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // hold_q keeps the last result; with OUT_REG it is also the output register.
    assign hold_d = v1_q ? merged : hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic ov_q, ov_d;

            assign ov_d = v1_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else begin
                    ov_q <= ov_d;
                end
            end

            assign bus.rd_valid = ov_q;
            assign bus.rd_data  = hold_q;
        end else begin : g_out_comb
            assign bus.rd_valid = v1_q;
            assign bus.rd_data  = v1_q ? merged : hold_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram2p_be_clr.sv
// Randomized and directed bench for ram2p_be_clr: two instances (write-first/no out reg,
// read-first/out reg) share stimulus and are checked each cycle against a word-level model.
module tb_ram2p_be_clr;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          BW    = 8;
    localparam int          NB    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INIT  = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NB-1:0] wr_be = '0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    ram2p_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) ifa ();
    ram2p_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) ifb ();

    assign ifa.rd_en   = rd_en;
    assign ifa.rd_addr = rd_addr;
    assign ifa.wr_en   = wr_en;
    assign ifa.wr_addr = wr_addr;
    assign ifa.wr_be   = wr_be;
    assign ifa.wr_data = wr_data;
    assign ifb.rd_en   = rd_en;
    assign ifb.rd_addr = rd_addr;
    assign ifb.wr_en   = wr_en;
    assign ifb.wr_addr = wr_addr;
    assign ifb.wr_be   = wr_be;
    assign ifb.wr_data = wr_data;

    ram2p_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
        .INIT_VALUE(INIT), .OUT_REG(0), .BYPASS(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    ram2p_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
        .INIT_VALUE(INIT), .OUT_REG(1), .BYPASS(0)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          clear_left  = DEPTH;
    logic [31:0] mem_m [DEPTH];
    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    // Word-level model: after DEPTH clean edges every word is INIT; then reads return
    // the pre-write word (read-first) or the byte-merged new word (write-first).
    task automatic model_edge();
        logic [31:0] old;
        logic        hit;
        cyc++;
        if (rst) begin
            clear_left = DEPTH;
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
            end
        end else begin
            if (rd_en) begin
                old = mem_m[rd_addr];
                hit = wr_en && (rd_addr == wr_addr);
                qa.push_back('{due: cyc,     data: hit ? merge(old, wr_data, wr_be) : old});
                qb.push_back('{due: cyc + 1, data: old});
            end
            if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
        end
    endtask

    task automatic compare();
        logic va, vb;
        va = (qa.size() > 0) && (qa[0].due == cyc);
        vb = (qb.size() > 0) && (qb[0].due == cyc);
        if (va) begin
            last_a = qa[0].data;
            void'(qa.pop_front());
        end
        if (vb) begin
            last_b = qb[0].data;
            void'(qb.pop_front());
        end
        check("a_busy",  32'(ifa.busy),     32'(clear_left > 0));
        check("a_valid", 32'(ifa.rd_valid), 32'(va));
        check("a_data",  ifa.rd_data,       last_a);
        check("b_busy",  32'(ifb.busy),     32'(clear_left > 0));
        check("b_valid", 32'(ifb.rd_valid), 32'(vb));
        check("b_data",  ifb.rd_data,       last_b);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input int be);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        wr_be   = NB'(be);
        tick();
        wr_en   = 1'b0;
    endtask

    // Issues one read (plus whatever write the caller staged) and checks both DUTs' result.
    task automatic rd_pair(input int addr, input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input string name);
        logic        sa, sb;
        logic [31:0] da, db;
        sa = 1'b0;
        sb = 1'b0;
        da = 'x;
        db = 'x;
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            if (ifa.rd_valid && !sa) begin
                sa = 1'b1;
                da = ifa.rd_data;
            end
            if (ifb.rd_valid && !sb) begin
                sb = 1'b1;
                db = ifb.rd_data;
            end
        end
        check({name, "_a_seen"}, 32'(sa), 32'd1);
        check({name, "_a"},      da,      exp_a);
        check({name, "_b_seen"}, 32'(sb), 32'd1);
        check({name, "_b"},      db,      exp_b);
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!ifa.busy) break;
            n++;
            tick();
        end
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        logic [5:0]  vbits;
        logic [31:0] gotq[$];

        repeat (3) tick();

        // Hostile traffic for the whole sweep: must be ignored.
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 32'hFFFFFFFF;
        wr_be   = 4'hF;
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        count_sweep("sweep_len");
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        check("model_init_pin", mem_m[2], INIT);

        for (int a = 0; a < DEPTH; a++) rd_pair(a, INIT, INIT, "init_word");

        wr(3, 32'h00000000, 'hF);
        wr(3, 32'h11223344, 'b0101);
        check("model_be_pin", mem_m[3], 32'h00220044);
        rd_pair(3, 32'h00220044, 32'h00220044, "be_lanes");

        wr(5, 32'hDEADBEEF, 'hF);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678; wr_be = 4'hF;
        rd_pair(5, 32'h12345678, 32'hDEADBEEF, "coll_full");
        rd_pair(5, 32'h12345678, 32'h12345678, "after_coll");
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAABBCCDD; wr_be = 4'b0011;
        rd_pair(5, 32'h1234CCDD, 32'h12345678, "coll_part");
        wr(5, 32'hFFFFFFFF, 0);
        rd_pair(5, 32'h1234CCDD, 32'h1234CCDD, "be_zero_noop");

        wr(0, 32'h100, 'hF);
        wr(1, 32'h101, 'hF);
        wr(2, 32'h102, 'hF);
        vbits = '0;
        for (int k = 0; k < 6; k++) begin
            rd_en   = (k < 3);
            rd_addr = AW'(k);
            tick();
            vbits[k] = ifb.rd_valid;
            if (ifb.rd_valid) gotq.push_back(ifb.rd_data);
        end
        rd_en = 1'b0;
        check("oreg_valid_pattern", 32'(vbits), 32'b001110);
        for (int i = 0; i < 3; i++) begin
            check("oreg_order", (i < gotq.size()) ? gotq[i] : 32'hxxxxxxxx, 32'h100 + 32'(i));
        end

        for (int n = 0; n < 400; n++) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 7));
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom_range(0, 7));
            wr_be   = NB'($urandom);
            wr_data = $urandom;
            tick();
        end

        // Reset with a read in flight, then reset again at sweep address 7.
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 4'd1;
        tick();
        rst   = 1'b1;
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_sweep("restart_len");
        tick();

        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            tick();
        end
        rd_en = 1'b0;
        repeat (3) tick();
        rd_pair(3, INIT, INIT, "resweep_3");
        rd_pair(7, INIT, INIT, "resweep_7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
